inst_buffer_queue: RTL and testbench
====================================

// Module: inst_buffer_queue
// PURPOSE
//  Instruction buffer between predecode and decode. Accepts up to IN_WIDTH compacted
//  instructions per cycle from predecode (PreDecodeIBufferIO side) and stores them in
//  a circular FIFO. Presents up to OUT_WIDTH in-order instructions per cycle to decode
//  (IfuBackendIO side) and drops them on backend stall. Raises full to throttle the
//  frontend and clears completely on redirect flush.
// PARAMETERS
//  DEPTH      32                 entries; power of 2, >= 2*IN_WIDTH
//  IN_WIDTH   `BLOCK_INST_SIZE   max instructions written per cycle
//  OUT_WIDTH  `FETCH_WIDTH       max instructions read per cycle
//  FSQ_W      `FSQ_WIDTH         fetch-stream-queue index width
//  OFF_W      `PREDICTION_WIDTH  slot offset width within a fetch block
// PORTS
//  clk        in   1                  clock
//  rst        in   1                  asynchronous reset, active-high
//  in_en      in   IN_WIDTH           lane valid; contiguous from lane 0
//  in_num     in   $clog2(IN_WIDTH)+1 popcount(in_en)
//  in_inst    in   IN_WIDTH*32        instruction per lane
//  in_fsqIdx  in   FSQ_W              fsq index shared by all lanes of this write
//  full       out  1                  buffer cannot accept a full IN_WIDTH write
//  flush      in   1                  frontend/backend redirect; discard all contents
//  stall      in   1                  decode cannot consume this cycle
//  out_en     out  OUT_WIDTH          output lane valid; contiguous from lane 0
//  out_inst   out  OUT_WIDTH*32       instruction per lane, program order
//  out_fsqIdx out  OUT_WIDTH*FSQ_W    fsq index per lane
//  out_offset out  OUT_WIDTH*OFF_W    original predecode lane index (slot in block)
// BEHAVIOUR
//  - Reset (async, rst=1): head=0, tail=0, count=0; full=0, out_en=0. Entry payloads
//    are not reset.
//  - Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. count is $clog2(DEPTH)+1 bits.
//  - full = (count > DEPTH-IN_WIDTH). It is combinational from registered count.
//  - Write: if in_num!=0 && !full && !flush, lane i (i<in_num) goes to entry
//    (tail+i)%DEPTH with {inst, in_fsqIdx, offset=i}. tail += in_num.
//  - Write while full is a protocol violation. RTL ignores it, leaving state unchanged,
//    and the bench asserts it never occurs.
//  - Output: out_en[i] = (count > i). Lane i is driven from entry (head+i)%DEPTH.
//    Outputs are combinational from registers. Write-to-visible latency is 1 cycle;
//    there is no same-cycle bypass.
//  - Read: if !stall && !flush, deq = min(count, OUT_WIDTH) and head += deq.
//    If stall=1, out_* are held stable and nothing is dequeued.
//  - Simultaneous enqueue and dequeue: count_next = count + enq - deq, where enq/deq
//    are 0 if not performed. Free space is judged on current count only; dequeued
//    slots are not reused in the same cycle.
//  - Flush has priority over write and read. Next cycle: head=tail=0, count=0,
//    out_en=0, full=0. Any write presented in the flush cycle is lost.
//  - Wrap-around: a write or read spanning entry DEPTH-1 -> 0 must be seamless and
//    keep order.
//  - Invariant: 0 <= count <= DEPTH, and count == (tail-head)%DEPTH except when
//    count == DEPTH (only reachable if IN_WIDTH divides DEPTH exactly at boundary).
// STRUCTURE
//  - Shared package (bundles): typedef struct packed IBufEntry {inst[31:0];
//    fsqIdx[FSQ_W]; offset[OFF_W]}. Widths come from `FSQ_WIDTH / `PREDICTION_WIDTH.
//  - Storage: flat IBufEntry array[DEPTH]. Per-lane write/read indices are computed
//    by modular add.
//  - No sub-module. A top-level wrapper binds the PreDecodeIBufferIO.instbuffer and
//    IfuBackendIO.ifu modports onto these ports.
// TESTING
//  1 Reset, idle: rst pulse, no input -> out_en=0, full=0 for 10 cycles.
//  2 Basic order: write 3 insts (0x11,0x22,0x33, fsqIdx=5), stall=0 -> next cycle
//    out_en=0b0111 (OUT_WIDTH=4), out_offset={0,1,2}, all fsqIdx=5; following
//    cycle out_en=0.
//  3 Full/stall: stall=1, write 8 per cycle with DEPTH=32 -> full=1 after count=32-8
//    reached (count 32 after 4 writes, full from count 25 up). Release stall ->
//    4 dequeued per cycle, full drops once count <= 24.
//  4 Wrap: pre-advance head/tail to 30, write 5 -> entries 30,31,0,1,2. Reads return
//    the same 5 in order across the wrap.
//  5 Flush collision: count=10, same cycle flush=1 + write 4 + stall=0 -> next cycle
//    count=0, out_en=0. A subsequent write of 2 appears at head=0 with offsets {0,1}.
//  6 Random: random in_num/stall/flush for 10k cycles against a scoreboard FIFO
//    model -> exact order/payload match, invariant holds, no write accepted while full.

Source files
------------

// File: rtl/inst_buffer_queue_pkg.sv
// Shared types and default widths for the predecode-to-decode instruction buffer.
package inst_buffer_queue_pkg;

    localparam int unsigned BLOCK_INST_SIZE  = 8;
    localparam int unsigned FETCH_WIDTH      = 4;
    localparam int unsigned FSQ_WIDTH        = 4;
    localparam int unsigned PREDICTION_WIDTH = 3;

    typedef struct packed {
        logic [31:0]                 inst;
        logic [FSQ_WIDTH-1:0]        fsq_idx;
        logic [PREDICTION_WIDTH-1:0] offset;
    } ibuf_entry_t;

endpackage

// File: rtl/inst_buffer_queue.sv
// Circular instruction FIFO: up to IN_WIDTH writes and OUT_WIDTH in-order reads per cycle,
// full throttles predecode, flush empties the queue.
module inst_buffer_queue
    import inst_buffer_queue_pkg::*;
#(
    parameter int unsigned DEPTH     = 32,
    parameter int unsigned IN_WIDTH  = BLOCK_INST_SIZE,
    parameter int unsigned OUT_WIDTH = FETCH_WIDTH
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [IN_WIDTH-1:0]                   in_en,
    input  logic [$clog2(IN_WIDTH):0]             in_num,
    input  logic [IN_WIDTH*32-1:0]                in_inst,
    input  logic [FSQ_WIDTH-1:0]                  in_fsqIdx,
    output logic                                  full,
    input  logic                                  flush,
    input  logic                                  stall,
    output logic [OUT_WIDTH-1:0]                  out_en,
    output logic [OUT_WIDTH*32-1:0]               out_inst,
    output logic [OUT_WIDTH*FSQ_WIDTH-1:0]        out_fsqIdx,
    output logic [OUT_WIDTH*PREDICTION_WIDTH-1:0] out_offset
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned NUM_W = $clog2(IN_WIDTH) + 1;

    ibuf_entry_t      mem [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] enq, deq;
    logic             do_write;
    logic [PTR_W-1:0] wr_idx [IN_WIDTH];
    logic [PTR_W-1:0] rd_idx [OUT_WIDTH];

    // Space is judged on the registered count; slots freed this cycle are not reused.
    assign full     = count_q > CNT_W'(DEPTH - IN_WIDTH);
    assign do_write = (in_num != '0) && !full && !flush;

    always_comb begin
        for (int i = 0; i < IN_WIDTH; i++) begin
            wr_idx[i] = tail_q + PTR_W'(i);
        end
        for (int i = 0; i < OUT_WIDTH; i++) begin
            rd_idx[i] = head_q + PTR_W'(i);
        end
    end

    always_comb begin
        enq = do_write ? CNT_W'(in_num) : '0;
        deq = '0;
        if (!stall && !flush) begin
            deq = (count_q > CNT_W'(OUT_WIDTH)) ? CNT_W'(OUT_WIDTH) : count_q;
        end
        head_d  = head_q + deq[PTR_W-1:0];
        tail_d  = tail_q + enq[PTR_W-1:0];
        count_d = count_q + enq - deq;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int i = 0; i < IN_WIDTH; i++) begin
                if (NUM_W'(i) < in_num && in_en[i]) begin
                    mem[wr_idx[i]] <= '{inst:    in_inst[i*32 +: 32],
                                        fsq_idx: in_fsqIdx,
                                        offset:  PREDICTION_WIDTH'(i)};
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < OUT_WIDTH; i++) begin
            out_en[i]                                          = count_q > CNT_W'(i);
            out_inst[i*32 +: 32]                               = mem[rd_idx[i]].inst;
            out_fsqIdx[i*FSQ_WIDTH +: FSQ_WIDTH]               = mem[rd_idx[i]].fsq_idx;
            out_offset[i*PREDICTION_WIDTH +: PREDICTION_WIDTH] = mem[rd_idx[i]].offset;
        end
    end

endmodule

// File: tb/tb_inst_buffer_queue.sv
// Directed and randomized self-checking bench for inst_buffer_queue.
module tb_inst_buffer_queue;
    import inst_buffer_queue_pkg::*;

    localparam int unsigned DEPTH = 32;
    localparam int unsigned IW    = BLOCK_INST_SIZE;
    localparam int unsigned OW    = FETCH_WIDTH;
    localparam int unsigned FW    = FSQ_WIDTH;
    localparam int unsigned OFW   = PREDICTION_WIDTH;
    localparam int unsigned NUM_W = $clog2(IW) + 1;

    logic                clk = 1'b0;
    logic                rst;
    logic [IW-1:0]       in_en;
    logic [NUM_W-1:0]    in_num;
    logic [IW*32-1:0]    in_inst;
    logic [FW-1:0]       in_fsqIdx;
    logic                full;
    logic                flush;
    logic                stall;
    logic [OW-1:0]       out_en;
    logic [OW*32-1:0]    out_inst;
    logic [OW*FW-1:0]    out_fsqIdx;
    logic [OW*OFW-1:0]   out_offset;

    int tests_run    = 0;
    int tests_failed = 0;

    inst_buffer_queue #(
        .DEPTH    (DEPTH),
        .IN_WIDTH (IW),
        .OUT_WIDTH(OW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_en     (in_en),
        .in_num    (in_num),
        .in_inst   (in_inst),
        .in_fsqIdx (in_fsqIdx),
        .full      (full),
        .flush     (flush),
        .stall     (stall),
        .out_en    (out_en),
        .out_inst  (out_inst),
        .out_fsqIdx(out_fsqIdx),
        .out_offset(out_offset)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle(input logic stall_v);
        in_en     = '0;
        in_num    = '0;
        in_inst   = '0;
        in_fsqIdx = '0;
        flush     = 1'b0;
        stall     = stall_v;
    endtask

    task automatic set_write(input int n, input logic [31:0] base, input logic [31:0] step,
                             input logic [FW-1:0] fsq);
        logic [IW:0] mask;
        mask      = (({{IW{1'b0}}, 1'b1}) << n) - 1'b1;
        in_en     = mask[IW-1:0];
        in_num    = NUM_W'(n);
        in_fsqIdx = fsq;
        in_inst   = '0;
        for (int i = 0; i < n; i++) begin
            in_inst[i*32 +: 32] = base + step * i;
        end
    endtask

    task automatic apply_reset();
        set_idle(1'b0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
    endtask

    task automatic check_lane(input string name, input int lane, input logic [31:0] inst,
                              input logic [FW-1:0] fsq, input logic [OFW-1:0] off);
        tests_run++;
        if (out_inst[lane*32 +: 32] !== inst || out_fsqIdx[lane*FW +: FW] !== fsq ||
            out_offset[lane*OFW +: OFW] !== off) begin
            tests_failed++;
            $display("FAIL %s lane%0d: got inst=%h fsq=%0d off=%0d, expected inst=%h fsq=%0d off=%0d",
                     name, lane, out_inst[lane*32 +: 32], out_fsqIdx[lane*FW +: FW],
                     out_offset[lane*OFW +: OFW], inst, fsq, off);
        end
    endtask

    task automatic check_status(input string name, input logic [OW-1:0] en, input logic f);
        tests_run++;
        if (out_en !== en || full !== f) begin
            tests_failed++;
            $display("FAIL %s: got out_en=%b full=%b, expected out_en=%b full=%b",
                     name, out_en, full, en, f);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_idle(1'b0);
        #2;
        check_status("reset_async", '0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            check_status("reset_idle", '0, 1'b0);
        end
    endtask

    task automatic test_basic_order();
        set_write(3, 32'h11, 32'h11, 4'd5);
        tick();
        set_idle(1'b0);
        check_status("basic_visible", 4'b0111, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check_lane("basic_lane", i, 32'h11 * (i + 1), 4'd5, OFW'(i));
        end
        tick();
        check_status("basic_drained", 4'b0000, 1'b0);
    endtask

    task automatic test_full_stall();
        for (int k = 0; k < 4; k++) begin
            set_write(8, 32'h100 + 32'(k * 8), 32'h1, 4'd9);
            stall = 1'b1;
            tick();
            set_idle(1'b1);
            // count = 8*(k+1); full only above 24
            check_status("fill", 4'b1111, (k == 3));
        end
        check_lane("fill_head", 0, 32'h100, 4'd9, 3'd0);
        set_idle(1'b0);
        tick();
        check_status("drain_28", 4'b1111, 1'b1);
        check_lane("drain_head", 0, 32'h104, 4'd9, 3'd4);
        tick();
        check_status("drain_24", 4'b1111, 1'b0);
        check_lane("drain_head2", 0, 32'h108, 4'd9, 3'd0);
        repeat (6) tick();
        check_status("drain_empty", 4'b0000, 1'b0);
    endtask

    task automatic test_wrap();
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            set_write((k == 3) ? 6 : 8, 32'h200, 32'h1, 4'd1);
            stall = 1'b1;
            tick();
        end
        set_idle(1'b0);
        repeat (8) tick();
        check_status("wrap_pre_empty", 4'b0000, 1'b0);
        set_write(5, 32'hA0, 32'h1, 4'd7);
        stall = 1'b1;
        tick();
        set_idle(1'b1);
        check_status("wrap_visible", 4'b1111, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check_lane("wrap_lane", i, 32'hA0 + 32'(i), 4'd7, OFW'(i));
        end
        tick();
        check_status("wrap_stall_hold", 4'b1111, 1'b0);
        check_lane("wrap_hold", 3, 32'hA3, 4'd7, 3'd3);
        set_idle(1'b0);
        tick();
        check_status("wrap_last", 4'b0001, 1'b0);
        check_lane("wrap_last", 0, 32'hA4, 4'd7, 3'd4);
        tick();
        check_status("wrap_empty", 4'b0000, 1'b0);
    endtask

    task automatic test_flush();
        apply_reset();
        set_write(8, 32'h300, 32'h1, 4'd2);
        stall = 1'b1;
        tick();
        set_write(2, 32'h308, 32'h1, 4'd2);
        stall = 1'b1;
        tick();
        set_idle(1'b1);
        check_status("flush_pre", 4'b1111, 1'b0);
        set_write(4, 32'h400, 32'h1, 4'd3);
        flush = 1'b1;
        stall = 1'b0;
        tick();
        set_idle(1'b1);
        check_status("flush_cleared", 4'b0000, 1'b0);
        tick();
        check_status("flush_write_lost", 4'b0000, 1'b0);
        set_write(2, 32'hB0, 32'h1, 4'd4);
        stall = 1'b1;
        tick();
        set_idle(1'b1);
        check_status("flush_after", 4'b0011, 1'b0);
        check_lane("flush_after", 0, 32'hB0, 4'd4, 3'd0);
        check_lane("flush_after", 1, 32'hB1, 4'd4, 3'd1);
    endtask

    task automatic test_random();
        ibuf_entry_t q[$];
        ibuf_entry_t e;
        logic        model_full;
        logic        exp_en;
        int          n;
        int          d;
        apply_reset();
        for (int c = 0; c < 10000; c++) begin
            model_full = q.size() > (DEPTH - IW);
            tests_run++;
            if (full !== model_full || q.size() > DEPTH) begin
                tests_failed++;
                $display("FAIL rand_full cyc%0d: got full=%b, expected full=%b (size %0d)",
                         c, full, model_full, q.size());
            end
            for (int l = 0; l < OW; l++) begin
                exp_en = (l < q.size());
                tests_run++;
                if (out_en[l] !== exp_en) begin
                    tests_failed++;
                    $display("FAIL rand_en cyc%0d lane%0d: got %b, expected %b",
                             c, l, out_en[l], exp_en);
                end else if (exp_en) begin
                    check_lane("rand_payload", l, q[l].inst, q[l].fsq_idx, q[l].offset);
                end
            end
            stall = ($urandom_range(0, 99) < 40);
            flush = ($urandom_range(0, 99) < 2);
            n     = model_full ? 0 : int'($urandom_range(0, IW));
            set_write(n, $urandom, 32'h9E3779B9, FW'($urandom));
            tests_run++;
            if (n != 0 && full) begin
                tests_failed++;
                $display("FAIL rand_write_while_full cyc%0d: got full=%b, expected full=0",
                         c, full);
            end
            if (flush) begin
                q.delete();
            end else begin
                if (!stall) begin
                    d = (q.size() > OW) ? OW : q.size();
                    for (int i = 0; i < d; i++) void'(q.pop_front());
                end
                for (int i = 0; i < n; i++) begin
                    e.inst    = in_inst[i*32 +: 32];
                    e.fsq_idx = in_fsqIdx;
                    e.offset  = OFW'(i);
                    q.push_back(e);
                end
            end
            tick();
        end
        set_idle(1'b0);
    endtask

    initial begin
        test_reset();
        test_basic_order();
        test_full_stall();
        test_wrap();
        test_flush();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
